// File: rtl/image_resize_pkg.sv
// -----------------------------------------------------------------------------
// image_resize_pkg
//   Shared definitions for the bilinear resize blender:
//   - channel-index to bit-range helpers for packed pixels (channel 0 in LSBs)
//   - unity weight (2^WT_FRAC) and round-to-nearest offset constants
//   - pipeline occupancy record used by the blender control
// -----------------------------------------------------------------------------
package image_resize_pkg;

  // Occupancy of the two register stages of the blender.
  typedef struct packed {
    logic s1_valid;
    logic s2_valid;
  } pipe_occ_t;

  // Lowest bit index of channel ch in a pixel of ch_w-bit channels.
  function automatic int ch_lsb(input int ch, input int ch_w);
    return ch * ch_w;
  endfunction

  // Highest bit index of channel ch in a pixel of ch_w-bit channels.
  function automatic int ch_msb(input int ch, input int ch_w);
    return (ch + 1) * ch_w - 1;
  endfunction

  // Weight value that represents 1.0 with frac fractional bits.
  function automatic longint unsigned unity_weight(input int frac);
    return 64'd1 << frac;
  endfunction

  // Half an LSB of the output in weight-fraction units; zero when truncating.
  function automatic longint unsigned round_offset(input int frac, input bit round_en);
    if (!round_en || frac < 1) begin
      return 64'd0;
    end
    return 64'd1 << (frac - 1);
  endfunction

endpackage

// File: rtl/image_resize_blend_lane.sv
// -----------------------------------------------------------------------------
// image_resize_blend_lane
//   One colour channel of the two-tap blender:
//     S1: p0 = d0*w0, p1 = d1*w1 (registered)
//     S2: q = (p0 + p1 + round) >> WT_FRAC, clamped to 2^CH_W-1 with a flag
//   Stage loading is controlled entirely by the parent; the lane holds its
//   registers whenever its load strobe is low.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   load1_i             capture new products into S1
//   load2_i             capture the blended result into S2
//   d0_i, d1_i          channel value of neighbour pixel 0 / 1
//   w0_i, w1_i          unsigned weights (WT_FRAC fractional bits)
//   data_o, sat_o       registered blended channel and saturation flag
// -----------------------------------------------------------------------------
module image_resize_blend_lane
  import image_resize_pkg::*;
#(
  parameter int CH_W     = 8,
  parameter int WT_W     = 9,
  parameter int WT_FRAC  = 8,
  parameter int ROUND_EN = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load1_i,
  input  logic            load2_i,
  input  logic [CH_W-1:0] d0_i,
  input  logic [CH_W-1:0] d1_i,
  input  logic [WT_W-1:0] w0_i,
  input  logic [WT_W-1:0] w1_i,
  output logic [CH_W-1:0] data_o,
  output logic            sat_o
);

  localparam int PW = CH_W + WT_W;  // product width
  localparam int SW = PW + 1;       // sum of two products
  localparam int RW = SW + 1;       // sum plus rounding term, never overflows

  localparam logic [RW-1:0] ROUND_OFS = RW'(round_offset(WT_FRAC, ROUND_EN != 0));

  logic [PW-1:0]   p0_q, p0_d;
  logic [PW-1:0]   p1_q, p1_d;
  logic [SW-1:0]   sum;
  logic [RW-1:0]   rnd;
  logic [RW-1:0]   q;
  logic [CH_W-1:0] data_q, data_d;
  logic            sat_q, sat_d;

  always_comb begin
    p0_d = p0_q;
    p1_d = p1_q;
    if (load1_i) begin
      p0_d = PW'(d0_i) * PW'(w0_i);
      p1_d = PW'(d1_i) * PW'(w1_i);
    end
  end

  always_comb begin
    sum    = {1'b0, p0_q} + {1'b0, p1_q};
    rnd    = {1'b0, sum} + ROUND_OFS;
    q      = rnd >> WT_FRAC;
    data_d = data_q;
    sat_d  = sat_q;
    if (load2_i) begin
      // Any bit above the channel width means the value exceeds full scale.
      sat_d  = |q[RW-1:CH_W];
      data_d = sat_d ? {CH_W{1'b1}} : q[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_q   <= '0;
      p1_q   <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/image_resize_bilinear_blend_pipe.sv
// -----------------------------------------------------------------------------
// image_resize_bilinear_blend_pipe
//   Two-stage, full-throughput weighted blender:
//     data_o[ch] = sat((d0[ch]*w0 + d1[ch]*w1 [+ half]) >> WT_FRAC)
//   with valid/ready on both sides. The per-channel arithmetic lives in
//   image_resize_blend_lane; this level owns the shared handshake and
//   stage-valid bookkeeping. WT_FRAC must satisfy 1 <= WT_FRAC <= WT_W.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   valid_i / ready_o    input beat handshake (ready_o is combinational
//                        from ready_i so a full pipe can push and pop
//                        on the same edge)
//   data0_i, data1_i     neighbour pixels, CH_NUM channels of CH_W bits
//   weight0_i/weight1_i  weights for data0_i / data1_i
//   valid_o / ready_i    output beat handshake
//   data_o, sat_o        blended pixel and per-channel saturation flags
// -----------------------------------------------------------------------------
module image_resize_bilinear_blend_pipe
  import image_resize_pkg::*;
#(
  parameter int CH_NUM   = 3,
  parameter int CH_W     = 8,
  parameter int WT_W     = 9,
  parameter int WT_FRAC  = 8,
  parameter int ROUND_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [CH_NUM*CH_W-1:0] data0_i,
  input  logic [CH_NUM*CH_W-1:0] data1_i,
  input  logic [WT_W-1:0]        weight0_i,
  input  logic [WT_W-1:0]        weight1_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CH_NUM*CH_W-1:0] data_o,
  output logic [CH_NUM-1:0]      sat_o
);

  pipe_occ_t occ_q, occ_d;
  logic      adv1;
  logic      adv2;
  logic      load1;
  logic      load2;

  // A stage may advance when it is empty or the stage after it advances.
  // S1 only captures real input beats, so idle cycles never disturb the
  // stored products; S2 only captures when S1 holds a beat.
  always_comb begin
    adv2  = !occ_q.s2_valid || ready_i;
    adv1  = !occ_q.s1_valid || adv2;
    load1 = adv1 && valid_i;
    load2 = adv2 && occ_q.s1_valid;
    occ_d = occ_q;
    if (adv1) begin
      occ_d.s1_valid = valid_i;
    end
    if (adv2) begin
      occ_d.s2_valid = occ_q.s1_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign ready_o = adv1;
  assign valid_o = occ_q.s2_valid;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_lane
      logic [CH_W-1:0] lane_data;
      logic            lane_sat;

      image_resize_blend_lane #(
        .CH_W     (CH_W),
        .WT_W     (WT_W),
        .WT_FRAC  (WT_FRAC),
        .ROUND_EN (ROUND_EN)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .load1_i (load1),
        .load2_i (load2),
        .d0_i    (data0_i[ch_lsb(gi, CH_W) +: CH_W]),
        .d1_i    (data1_i[ch_lsb(gi, CH_W) +: CH_W]),
        .w0_i    (weight0_i),
        .w1_i    (weight1_i),
        .data_o  (lane_data),
        .sat_o   (lane_sat)
      );

      assign data_o[ch_lsb(gi, CH_W) +: CH_W] = lane_data;
      assign sat_o[gi]                        = lane_sat;
    end
  endgenerate

endmodule

// File: tb/tb_image_resize_bilinear_blend_pipe.sv
// -----------------------------------------------------------------------------
// tb_image_resize_bilinear_blend_pipe
//   Directed checks on the default configuration (rounding), a truncating
//   twin sharing the same stimulus, and a 1x10-bit variant with a randomised
//   scoreboard run. Inputs change and outputs are sampled just after the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_image_resize_bilinear_blend_pipe;

  logic        clk;
  logic        reset_n;

  // Default configuration (ROUND_EN = 1) and truncating twin share inputs.
  logic        valid_i;
  logic        ready_o;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [8:0]  w0;
  logic [8:0]  w1;
  logic        valid_o;
  logic        ready_i;
  logic [23:0] data_o;
  logic [2:0]  sat_o;

  logic        tr_ready_o;
  logic        tr_valid_o;
  logic [23:0] tr_data_o;
  logic [2:0]  tr_sat_o;

  // Variant: CH_NUM=1, CH_W=10, WT_W=12, WT_FRAC=10, ROUND_EN=1.
  logic        p_valid_i;
  logic        p_ready_o;
  logic [9:0]  p_d0;
  logic [9:0]  p_d1;
  logic [11:0] p_w0;
  logic [11:0] p_w1;
  logic        p_valid_o;
  logic        p_ready_i;
  logic [9:0]  p_data_o;
  logic [0:0]  p_sat_o;

  int total;
  int bad;

  image_resize_bilinear_blend_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data0_i   (data0),
    .data1_i   (data1),
    .weight0_i (w0),
    .weight1_i (w1),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .sat_o     (sat_o)
  );

  image_resize_bilinear_blend_pipe #(.ROUND_EN(0)) dut_tr (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (valid_i),
    .ready_o   (tr_ready_o),
    .data0_i   (data0),
    .data1_i   (data1),
    .weight0_i (w0),
    .weight1_i (w1),
    .valid_o   (tr_valid_o),
    .ready_i   (ready_i),
    .data_o    (tr_data_o),
    .sat_o     (tr_sat_o)
  );

  image_resize_bilinear_blend_pipe #(
    .CH_NUM(1), .CH_W(10), .WT_W(12), .WT_FRAC(10), .ROUND_EN(1)
  ) dut_p (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (p_valid_i),
    .ready_o   (p_ready_o),
    .data0_i   (p_d0),
    .data1_i   (p_d1),
    .weight0_i (p_w0),
    .weight1_i (p_w1),
    .valid_o   (p_valid_o),
    .ready_i   (p_ready_i),
    .data_o    (p_data_o),
    .sat_o     (p_sat_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the next sample point: just after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Present one beat for a cycle, then wait so the beat sits on data_o.
  task automatic send_one(input logic [23:0] d0, input logic [23:0] d1,
                          input logic [8:0] a, input logic [8:0] b);
    valid_i = 1'b1;
    data0   = d0;
    data1   = d1;
    w0      = a;
    w1      = b;
    cyc();
    valid_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    data0     = '0;
    data1     = '0;
    w0        = '0;
    w1        = '0;
    p_valid_i = 1'b0;
    p_ready_i = 1'b1;
    p_d0      = '0;
    p_d1      = '0;
    p_w0      = '0;
    p_w1      = '0;
    cyc();
    cyc();
    total++;
    if (valid_o !== 1'b0 || data_o !== 24'h0 || sat_o !== 3'b000) begin
      $display("FAIL reset_state: valid_o=%b data_o=%h sat_o=%b required 0/000000/000",
               valid_o, data_o, sat_o);
      bad++;
    end
    reset_n = 1'b1;
    cyc();
    total++;
    if (ready_o !== 1'b1 || p_valid_o !== 1'b0) begin
      $display("FAIL reset_ready: ready_o=%b p_valid_o=%b required 1/0", ready_o, p_valid_o);
      bad++;
    end
  endtask

  task automatic test_passthrough();
    valid_i = 1'b1;
    data0   = 24'h123456;
    data1   = 24'hABCDEF;
    w0      = 9'd256;
    w1      = 9'd0;
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      $display("FAIL pass_ready: ready_o=%b required 1", ready_o);
      bad++;
    end
    cyc();
    valid_i = 1'b0;
    data0   = 24'h000000;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      $display("FAIL pass_early: valid_o=%b one cycle after acceptance, required 0", valid_o);
      bad++;
    end
    cyc();
    total++;
    if (valid_o !== 1'b1 || data_o !== 24'h123456 || sat_o !== 3'b000) begin
      $display("FAIL pass_data: valid_o=%b data_o=%h sat_o=%b required 1/123456/000",
               valid_o, data_o, sat_o);
      bad++;
    end
    cyc();
    total++;
    if (valid_o !== 1'b0) begin
      $display("FAIL pass_single: valid_o=%b after pop, required 0", valid_o);
      bad++;
    end
  endtask

  task automatic test_rounding();
    send_one(24'h000000, 24'h010101, 9'd128, 9'd128);
    total++;
    if (valid_o !== 1'b1 || data_o !== 24'h010101) begin
      $display("FAIL round_nearest: valid_o=%b data_o=%h required 1/010101", valid_o, data_o);
      bad++;
    end
    total++;
    if (tr_valid_o !== 1'b1 || tr_data_o !== 24'h000000 || tr_ready_o !== 1'b1) begin
      $display("FAIL round_truncate: valid_o=%b data_o=%h ready_o=%b required 1/000000/1",
               tr_valid_o, tr_data_o, tr_ready_o);
      bad++;
    end
  endtask

  task automatic test_saturation();
    send_one(24'hFF80FF, 24'hFF80FF, 9'd256, 9'd256);
    total++;
    if (data_o !== 24'hFFFFFF || sat_o !== 3'b111) begin
      $display("FAIL sat_all: data_o=%h sat_o=%b required FFFFFF/111", data_o, sat_o);
      bad++;
    end
    total++;
    if (tr_data_o !== 24'hFFFFFF || tr_sat_o !== 3'b111) begin
      $display("FAIL sat_trunc: data_o=%h sat_o=%b required FFFFFF/111", tr_data_o, tr_sat_o);
      bad++;
    end
    send_one(24'h101010, 24'h101010, 9'd256, 9'd16);
    total++;
    if (data_o !== 24'h111111 || sat_o !== 3'b000) begin
      $display("FAIL over_unity: data_o=%h sat_o=%b required 111111/000", data_o, sat_o);
      bad++;
    end
    // Exactly full scale on channel 0 must not raise the flag.
    send_one(24'h0000FF, 24'h000000, 9'd256, 9'd0);
    total++;
    if (data_o !== 24'h0000FF || sat_o !== 3'b000) begin
      $display("FAIL full_scale: data_o=%h sat_o=%b required 0000FF/000", data_o, sat_o);
      bad++;
    end
    send_one(24'hFFFFFF, 24'hFFFFFF, 9'd0, 9'd0);
    total++;
    if (valid_o !== 1'b1 || data_o !== 24'h000000 || sat_o !== 3'b000) begin
      $display("FAIL zero_weight: valid_o=%b data_o=%h sat_o=%b required 1/000000/000",
               valid_o, data_o, sat_o);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    // ch0 = (16k*128 + 32*128 + 128) >> 8 = 8k + 16
    logic [23:0] exp_tab [4];
    exp_tab[0] = 24'h000010;
    exp_tab[1] = 24'h000018;
    exp_tab[2] = 24'h000020;
    exp_tab[3] = 24'h000028;
    w0 = 9'd128;
    w1 = 9'd128;
    data1 = 24'h000020;
    for (int k = 0; k < 6; k++) begin
      valid_i = (k < 4);
      data0   = 24'(16 * k);
      #1;
      if (k >= 2) begin
        total++;
        if (valid_o !== 1'b1 || data_o !== exp_tab[k-2]) begin
          $display("FAIL b2b_beat%0d: valid_o=%b data_o=%h required 1/%h",
                   k - 2, valid_o, data_o, exp_tab[k-2]);
          bad++;
        end
      end
      cyc();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int          in_idx;
    int          out_idx;
    int          pops_after;
    logic [23:0] held;
    logic        held_v;
    in_idx     = 0;
    out_idx    = 0;
    pops_after = 0;
    held_v     = 1'b0;
    held       = '0;
    w0         = 9'd256;
    w1         = 9'd0;
    data1      = 24'hFFFFFF;
    for (int c = 0; c < 20; c++) begin
      ready_i = !(c >= 3 && c <= 6);
      valid_i = (in_idx < 8);
      data0   = 24'(in_idx);
      #1;
      if (held_v) begin
        total++;
        if (valid_o !== 1'b1 || data_o !== held) begin
          $display("FAIL bp_hold c%0d: valid_o=%b data_o=%h required 1/%h",
                   c, valid_o, data_o, held);
          bad++;
        end
      end
      if (c >= 3 && c <= 6) begin
        total++;
        if (ready_o !== 1'b0) begin
          $display("FAIL bp_ready_low c%0d: ready_o=%b required 0", c, ready_o);
          bad++;
        end
      end
      held_v = valid_o && !ready_i;
      held   = data_o;
      if (valid_o && ready_i) begin
        total++;
        if (data_o !== 24'(out_idx)) begin
          $display("FAIL bp_order c%0d: data_o=%h required %h", c, data_o, 24'(out_idx));
          bad++;
        end
        out_idx++;
        if (c >= 7) pops_after++;
      end
      if (valid_i && ready_o) in_idx++;
      cyc();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    total++;
    if (out_idx !== 8 || in_idx !== 8) begin
      $display("FAIL bp_count: received=%0d accepted=%0d required 8/8", out_idx, in_idx);
      bad++;
    end
    total++;
    if (pops_after !== 7) begin
      $display("FAIL bp_rate: pops after release=%0d required 7", pops_after);
      bad++;
    end
  endtask

  task automatic test_reset_midstream();
    ready_i = 1'b1;
    w0      = 9'd256;
    w1      = 9'd0;
    data1   = 24'h000000;
    valid_i = 1'b1;
    data0   = 24'h111111;
    cyc();
    data0   = 24'h222222;
    cyc();
    valid_i = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b1 || data_o !== 24'h111111) begin
      $display("FAIL rst_inflight: valid_o=%b data_o=%h required 1/111111", valid_o, data_o);
      bad++;
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0 || data_o !== 24'h0 || sat_o !== 3'b000) begin
      $display("FAIL rst_async: valid_o=%b data_o=%h sat_o=%b required 0/000000/000",
               valid_o, data_o, sat_o);
      bad++;
    end
    cyc();
    reset_n = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      $display("FAIL rst_release: valid_o=%b ready_o=%b required 0/1", valid_o, ready_o);
      bad++;
    end
    valid_i = 1'b1;
    data0   = 24'h333333;
    cyc();
    valid_i = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0) begin
      $display("FAIL rst_lat_early: valid_o=%b required 0", valid_o);
      bad++;
    end
    cyc();
    total++;
    if (valid_o !== 1'b1 || data_o !== 24'h333333) begin
      $display("FAIL rst_lat: valid_o=%b data_o=%h required 1/333333", valid_o, data_o);
      bad++;
    end
    cyc();
    total++;
    if (valid_o !== 1'b0) begin
      $display("FAIL rst_flushed: valid_o=%b data_o=%h required 0 (stale beat)", valid_o, data_o);
      bad++;
    end
  endtask

  task automatic test_param_variant();
    logic [10:0] exp_q[$];
    longint      s;
    longint      qv;
    int          in_cnt;
    int          out_cnt;
    int          cycles;
    logic        acc;
    logic [10:0] e;
    p_ready_i = 1'b1;
    p_valid_i = 1'b1;
    p_d0      = 10'd1023;
    p_d1      = 10'd0;
    p_w0      = 12'd512;
    p_w1      = 12'd512;
    cyc();
    p_valid_i = 1'b0;
    cyc();
    total++;
    if (p_valid_o !== 1'b1 || p_data_o !== 10'd512 || p_sat_o !== 1'b0) begin
      $display("FAIL var_half: valid_o=%b data_o=%0d sat_o=%b required 1/512/0",
               p_valid_o, p_data_o, p_sat_o);
      bad++;
    end
    cyc();

    in_cnt  = 0;
    out_cnt = 0;
    cycles  = 0;
    while (out_cnt < 10000 && cycles < 60000) begin
      if (!p_valid_i && in_cnt < 10000 && $urandom_range(0, 3) != 0) begin
        p_valid_i = 1'b1;
        p_d0      = 10'($urandom_range(0, 1023));
        p_d1      = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 0) begin
          p_w0 = 12'($urandom_range(0, 1024));
          p_w1 = 12'd1024 - p_w0;
        end else begin
          p_w0 = 12'($urandom_range(0, 4095));
          p_w1 = 12'($urandom_range(0, 4095));
        end
      end
      p_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (p_valid_o && p_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL var_extra: unexpected beat data_o=%0d", p_data_o);
          bad++;
        end else begin
          e = exp_q.pop_front();
          if (p_data_o !== e[9:0] || p_sat_o !== e[10]) begin
            $display("FAIL var_rand beat%0d: data_o=%0d sat_o=%b required %0d/%b",
                     out_cnt, p_data_o, p_sat_o, e[9:0], e[10]);
            bad++;
          end
        end
        out_cnt++;
      end
      acc = p_valid_i && p_ready_o;
      if (acc) begin
        s  = longint'(p_d0) * longint'(p_w0) + longint'(p_d1) * longint'(p_w1) + 512;
        qv = s >>> 10;
        if (qv > 1023) exp_q.push_back({1'b1, 10'd1023});
        else           exp_q.push_back({1'b0, 10'(qv)});
        in_cnt++;
      end
      cyc();
      if (acc) p_valid_i = 1'b0;
      cycles++;
    end
    p_valid_i = 1'b0;
    total++;
    if (out_cnt !== 10000) begin
      $display("FAIL var_timeout: received=%0d required 10000 within cycle budget", out_cnt);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_passthrough();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_param_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
